// File: rtl/priority_bit_scanner.sv
// Sequential priority scanner: accepts a request vector and emits the index of
// every set bit, one per accepted transfer, in the configured priority order.
`timescale 1ns/1ps

module priority_bit_scanner #(
    parameter int unsigned WIDTH        = 8,
    parameter bit          LOW_PRIORITY = 1'b1,
    localparam int unsigned IDX_W       = $clog2(WIDTH),
    localparam int unsigned CNT_W       = IDX_W + 1
) (
    input  logic             Clock_In,
    input  logic             Reset_n_In,
    input  logic             Enable_In,
    input  logic [WIDTH-1:0] Data_In,
    input  logic             Data_Valid_In,
    output logic             Data_Ready_Out,
    output logic [IDX_W-1:0] Encoded_Value_Out,
    output logic             Encoded_Valid_Out,
    input  logic             Encoded_Ready_In,
    output logic             Last_Out,
    output logic             None_Out,
    output logic [CNT_W-1:0] Remaining_Out
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] pending_next;
    logic             none_flag;
    logic             none_next;
    logic [IDX_W-1:0] prio_idx;
    logic [CNT_W-1:0] pop_cnt;

    // Priority index of the pending vector (lowest or highest set bit)
    always_comb begin
        prio_idx = '0;
        if (LOW_PRIORITY) begin
            for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
                if (pending[i]) prio_idx = IDX_W'(i);
            end
        end else begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (pending[i]) prio_idx = IDX_W'(i);
            end
        end
    end

    // Population count of pending bits; one extra bit so all-ones fits
    always_comb begin
        pop_cnt = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            pop_cnt = pop_cnt + CNT_W'(pending[i]);
        end
    end

    // State, pending vector and empty-load flag registers
    always_ff @(posedge Clock_In or negedge Reset_n_In) begin
        if (!Reset_n_In) begin
            state     <= IDLE;
            pending   <= '0;
            none_flag <= 1'b0;
        end else begin
            state     <= state_next;
            pending   <= pending_next;
            none_flag <= none_next;
        end
    end

    // Next-state logic and register-derived outputs
    always_comb begin
        state_next        = state;
        pending_next      = pending;
        none_next         = 1'b0;
        Data_Ready_Out    = 1'b0;
        Encoded_Valid_Out = 1'b0;
        Encoded_Value_Out = '0;
        Last_Out          = 1'b0;
        Remaining_Out     = '0;
        None_Out          = none_flag;

        case (state)
            IDLE: begin
                // Ready is held low while reset is asserted
                Data_Ready_Out = Enable_In & Reset_n_In;
                if (Enable_In && Data_Valid_In) begin
                    pending_next = Data_In;
                    if (Data_In != '0) begin
                        state_next = SCAN;
                    end else begin
                        none_next = 1'b1;
                    end
                end
            end
            SCAN: begin
                Encoded_Valid_Out = 1'b1;
                Encoded_Value_Out = prio_idx;
                Last_Out          = (pop_cnt == CNT_W'(1));
                Remaining_Out     = pop_cnt;
                if (Encoded_Ready_In) begin
                    pending_next = pending & ~(WIDTH'(1) << prio_idx);
                end
                if (!Enable_In) begin
                    pending_next = '0;
                    state_next   = IDLE;
                end else if (Encoded_Ready_In && (pop_cnt == CNT_W'(1))) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next   = IDLE;
                pending_next = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_priority_bit_scanner.sv
// Bench for priority_bit_scanner: directed 8-bit scenarios on both priority
// orders, then 16-bit randomized vectors against a queue-based reference.
`timescale 1ns/1ps

module tb_priority_bit_scanner;

    logic clk;
    logic rst_n;

    // 8-bit pair (shared stimulus, opposite priority)
    logic       en8, dv8, er8;
    logic [7:0] din8;
    logic       dr_lo, vld_lo, last_lo, none_lo;
    logic [2:0] val_lo;
    logic [3:0] rem_lo;
    logic       dr_hi, vld_hi, last_hi, none_hi;
    logic [2:0] val_hi;
    logic [3:0] rem_hi;

    // 16-bit pair (shared stimulus, opposite priority)
    logic        en16, dv16, er16;
    logic [15:0] din16;
    logic        dr_l16, vld_l16, last_l16, none_l16;
    logic [3:0]  val_l16;
    logic [4:0]  rem_l16;
    logic        dr_h16, vld_h16, last_h16, none_h16;
    logic [3:0]  val_h16;
    logic [4:0]  rem_h16;

    int errors = 0;
    int checks = 0;

    priority_bit_scanner #(.WIDTH(8), .LOW_PRIORITY(1'b1)) u_lo8 (
        .Clock_In(clk), .Reset_n_In(rst_n), .Enable_In(en8), .Data_In(din8),
        .Data_Valid_In(dv8), .Data_Ready_Out(dr_lo), .Encoded_Value_Out(val_lo),
        .Encoded_Valid_Out(vld_lo), .Encoded_Ready_In(er8), .Last_Out(last_lo),
        .None_Out(none_lo), .Remaining_Out(rem_lo)
    );

    priority_bit_scanner #(.WIDTH(8), .LOW_PRIORITY(1'b0)) u_hi8 (
        .Clock_In(clk), .Reset_n_In(rst_n), .Enable_In(en8), .Data_In(din8),
        .Data_Valid_In(dv8), .Data_Ready_Out(dr_hi), .Encoded_Value_Out(val_hi),
        .Encoded_Valid_Out(vld_hi), .Encoded_Ready_In(er8), .Last_Out(last_hi),
        .None_Out(none_hi), .Remaining_Out(rem_hi)
    );

    priority_bit_scanner #(.WIDTH(16), .LOW_PRIORITY(1'b1)) u_lo16 (
        .Clock_In(clk), .Reset_n_In(rst_n), .Enable_In(en16), .Data_In(din16),
        .Data_Valid_In(dv16), .Data_Ready_Out(dr_l16), .Encoded_Value_Out(val_l16),
        .Encoded_Valid_Out(vld_l16), .Encoded_Ready_In(er16), .Last_Out(last_l16),
        .None_Out(none_l16), .Remaining_Out(rem_l16)
    );

    priority_bit_scanner #(.WIDTH(16), .LOW_PRIORITY(1'b0)) u_hi16 (
        .Clock_In(clk), .Reset_n_In(rst_n), .Enable_In(en16), .Data_In(din16),
        .Data_Valid_In(dv16), .Data_Ready_Out(dr_h16), .Encoded_Value_Out(val_h16),
        .Encoded_Valid_Out(vld_h16), .Encoded_Ready_In(er16), .Last_Out(last_h16),
        .None_Out(none_h16), .Remaining_Out(rem_h16)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends
    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Check both 8-bit scanners against expected low/high-priority views
    task automatic exp8(input string tag, input logic e_vld, input int e_lo, input int e_hi,
                        input int e_rem, input logic e_llast, input logic e_hlast);
        chk({tag, ".vld_lo"},  32'(vld_lo),  32'(e_vld));
        chk({tag, ".vld_hi"},  32'(vld_hi),  32'(e_vld));
        chk({tag, ".val_lo"},  32'(val_lo),  32'(e_lo));
        chk({tag, ".val_hi"},  32'(val_hi),  32'(e_hi));
        chk({tag, ".rem_lo"},  32'(rem_lo),  32'(e_rem));
        chk({tag, ".rem_hi"},  32'(rem_hi),  32'(e_rem));
        chk({tag, ".last_lo"}, 32'(last_lo), 32'(e_llast));
        chk({tag, ".last_hi"}, 32'(last_hi), 32'(e_hlast));
    endtask

    // Present a vector for one edge, starting and ending on a falling edge
    task automatic load8(input logic [7:0] v);
        chk("load8.ready", 32'(dr_lo & dr_hi), 32'd1);
        din8 = v;
        dv8  = 1'b1;
        @(negedge clk);
        dv8  = 1'b0;
    endtask

    initial begin
        int lq[$];
        int hq[$];
        logic [15:0] v;
        int cyc;
        logic r;

        rst_n = 1'b0;
        en8 = 1'b0; dv8 = 1'b0; er8 = 1'b0; din8 = '0;
        en16 = 1'b0; dv16 = 1'b0; er16 = 1'b0; din16 = '0;

        // Reset state
        repeat (2) @(negedge clk);
        exp8("rst", 1'b0, 0, 0, 0, 1'b0, 1'b0);
        chk("rst.none", 32'(none_lo | none_hi), 32'd0);
        rst_n = 1'b1;
        en8   = 1'b1;
        en16  = 1'b1;
        #1;
        chk("rst.ready_after", 32'(dr_lo & dr_hi & dr_l16 & dr_h16), 32'd1);
        @(negedge clk);

        // Vector A4 at full throughput: low order 2,5,7; high order 7,5,2
        er8 = 1'b1;
        load8(8'hA4);
        exp8("t2a", 1'b1, 2, 7, 3, 1'b0, 1'b0);
        chk("t2a.ready", 32'(dr_lo), 32'd0);
        @(negedge clk);
        exp8("t2b", 1'b1, 5, 5, 2, 1'b0, 1'b0);
        @(negedge clk);
        exp8("t2c", 1'b1, 7, 2, 1, 1'b1, 1'b1);
        @(negedge clk);
        exp8("t2d", 1'b0, 0, 0, 0, 1'b0, 1'b0);
        chk("t2d.ready", 32'(dr_lo & dr_hi), 32'd1);

        // Backpressure holds the presented index
        er8 = 1'b0;
        load8(8'hA4);
        for (int k = 0; k < 4; k++) begin
            exp8("t4hold", 1'b1, 2, 7, 3, 1'b0, 1'b0);
            if (k < 3) @(negedge clk);
        end
        er8 = 1'b1;
        @(negedge clk);
        exp8("t4b", 1'b1, 5, 5, 2, 1'b0, 1'b0);
        @(negedge clk);
        exp8("t4c", 1'b1, 7, 2, 1, 1'b1, 1'b1);
        @(negedge clk);
        exp8("t4d", 1'b0, 0, 0, 0, 1'b0, 1'b0);

        // All-zero vector: single None pulse
        load8(8'h00);
        chk("t5.none_lo", 32'(none_lo), 32'd1);
        chk("t5.none_hi", 32'(none_hi), 32'd1);
        chk("t5.vld", 32'(vld_lo | vld_hi), 32'd0);
        chk("t5.ready", 32'(dr_lo), 32'd1);
        @(negedge clk);
        chk("t5.none_gone", 32'(none_lo | none_hi), 32'd0);
        chk("t5.vld2", 32'(vld_lo | vld_hi), 32'd0);

        // Abort after first transfer
        er8 = 1'b1;
        load8(8'hFF);
        exp8("t6a", 1'b1, 0, 7, 8, 1'b0, 1'b0);
        en8 = 1'b0;
        @(negedge clk);
        exp8("t6b", 1'b0, 0, 0, 0, 1'b0, 1'b0);
        chk("t6b.ready", 32'(dr_lo | dr_hi), 32'd0);
        chk("t6b.none", 32'(none_lo | none_hi), 32'd0);
        er8 = 1'b0;
        @(negedge clk);
        chk("t6c.ready", 32'(dr_lo), 32'd0);
        en8 = 1'b1;
        #1;
        chk("t6d.ready", 32'(dr_lo & dr_hi), 32'd1);
        @(negedge clk);

        // Reset asserted mid-scan clears outputs without a clock edge
        er8 = 1'b0;
        load8(8'hFF);
        chk("t1.vld_before", 32'(vld_lo), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        exp8("t1.async", 1'b0, 0, 0, 0, 1'b0, 1'b0);
        chk("t1.ready_in_rst", 32'(dr_lo | dr_hi), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("t1.ready_after", 32'(dr_lo & dr_hi), 32'd1);
        exp8("t1.idle", 1'b0, 0, 0, 0, 1'b0, 1'b0);
        @(negedge clk);

        // Randomized 16-bit vectors against queue reference
        for (int n = 0; n < 200; n++) begin
            v = (($urandom % 8) == 0) ? 16'h0000 : 16'($urandom);
            lq.delete();
            hq.delete();
            for (int i = 0; i < 16; i++) if (v[i]) lq.push_back(i);
            for (int i = 15; i >= 0; i--) if (v[i]) hq.push_back(i);

            chk("rnd.ready", 32'(dr_l16 & dr_h16), 32'd1);
            din16 = v;
            dv16  = 1'b1;
            @(negedge clk);
            dv16  = 1'b0;
            din16 = 16'($urandom);

            if (lq.size() == 0) begin
                chk("rnd.none_l", 32'(none_l16), 32'd1);
                chk("rnd.none_h", 32'(none_h16), 32'd1);
                chk("rnd.zero_vld", 32'(vld_l16 | vld_h16), 32'd0);
            end else begin
                cyc = 0;
                while (lq.size() > 0 && cyc < 200) begin
                    chk("rnd.vld", 32'(vld_l16 & vld_h16), 32'd1);
                    chk("rnd.val_l", 32'(val_l16), 32'(lq[0]));
                    chk("rnd.val_h", 32'(val_h16), 32'(hq[0]));
                    chk("rnd.rem", 32'({rem_l16, rem_h16}), 32'({5'(lq.size()), 5'(hq.size())}));
                    chk("rnd.last", 32'({last_l16, last_h16}), (lq.size() == 1) ? 32'd3 : 32'd0);
                    chk("rnd.busy", 32'(dr_l16 | dr_h16), 32'd0);
                    r = 1'($urandom);
                    er16 = r;
                    if (r) begin
                        void'(lq.pop_front());
                        void'(hq.pop_front());
                    end
                    @(negedge clk);
                    cyc++;
                end
                er16 = 1'b0;
                chk("rnd.drained", 32'(lq.size()), 32'd0);
                chk("rnd.idle_vld", 32'(vld_l16 | vld_h16), 32'd0);
                chk("rnd.idle_none", 32'(none_l16 | none_h16), 32'd0);
                chk("rnd.idle_rem", 32'(rem_l16 | rem_h16), 32'd0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
